// File: rtl/alu_txn_if.sv
// Bundle between the ALU command/result stream, the capture block and the record reader.
// The slave modport is the capture block's view. The master modport is the
// ALU-plus-reader side that drives commands and txn_ready.
// The txn_ts field exists only when ALU_CAP_TIMESTAMP_EN is defined.
//
// Handshake: a record moves from the capture block to the reader at a rising clk edge
// where txn_valid && txn_ready. While txn_valid is high and txn_ready is low, txn_rec
// (and txn_ts) hold steady. txn_valid never waits on txn_ready.
interface alu_txn_if #(
  parameter int DATA_W = 8,
  parameter int A_OP_W = 3,
  parameter int B_OP_W = 2,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
);
  localparam int REC_W = 2*DATA_W + A_OP_W + B_OP_W + 2 + DATA_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // ALU command/result stream, which is observed only
  logic              alu_en;
  logic              a_en;
  logic              b_en;
  logic [A_OP_W-1:0] a_op;
  logic [B_OP_W-1:0] b_op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] c;

  // record read port and status
  logic              txn_valid;
  logic              txn_ready;
  logic [REC_W-1:0]  txn_rec;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
`ifdef ALU_CAP_TIMESTAMP_EN
  logic [31:0]       txn_ts;
`endif

  modport master (
    output alu_en, a_en, b_en, a_op, b_op, A, B, c, txn_ready,
    input  txn_valid, txn_rec, level, overflow, drop_cnt
`ifdef ALU_CAP_TIMESTAMP_EN
    , input txn_ts
`endif
  );

  modport slave (
    input  alu_en, a_en, b_en, a_op, b_op, A, B, c, txn_ready,
    output txn_valid, txn_rec, level, overflow, drop_cnt
`ifdef ALU_CAP_TIMESTAMP_EN
    , output txn_ts
`endif
  );
endinterface

// File: rtl/alu_txn_capture.sv
// alu_txn_capture: passive observer of the ALU command/result stream.
// On every cycle with alu_en high, the command fields enter a RES_LAT-deep alignment pipe.
// RES_LAT edges later, the record is completed with the c value sampled at that edge and
// pushed into a DEPTH-entry FIFO. A valid/ready reader drains the FIFO.
// If the FIFO is full and no pop happens, the record is dropped. The drop sets the
// sticky overflow flag and increments a saturating drop counter.
// Optional feature macro: ALU_CAP_TIMESTAMP_EN. When it is defined, a free-running 32-bit
// cycle counter is added and each record carries the counter value from its command edge.
module alu_txn_capture #(
  parameter int DATA_W  = 8,
  parameter int A_OP_W  = 3,
  parameter int B_OP_W  = 2,
  parameter int RES_LAT = 1,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_txn_if.slave bus
);
  localparam int CMD_W = 2 + A_OP_W + B_OP_W + 2*DATA_W;
  localparam int REC_W = CMD_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Alignment pipe: command fields wait here until their result arrives
  logic             pipe_v   [RES_LAT];
  logic [CMD_W-1:0] pipe_cmd [RES_LAT];
  logic [CMD_W-1:0] cmd_in;

  // FIFO storage and bookkeeping
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_q;

  logic             push;
  logic [REC_W-1:0] push_rec;
  logic             is_empty;
  logic             is_full;
  logic             pop;
  logic             wr_en;
  logic             drop;

`ifdef ALU_CAP_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] pipe_ts [RES_LAT];
  logic [31:0] mem_ts  [DEPTH];
`endif

  assign cmd_in = {bus.a_en, bus.b_en, bus.a_op, bus.b_op, bus.A, bus.B};

  // Shift the command fields and their valid bit; alu_en=0 inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RES_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_cmd[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= bus.alu_en;
      pipe_cmd[0] <= cmd_in;
      for (int i = 1; i < RES_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_cmd[i] <= pipe_cmd[i-1];
      end
    end
  end

`ifdef ALU_CAP_TIMESTAMP_EN
  // Free-running cycle counter, plus the timestamps that travel alongside the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < RES_LAT; i++) pipe_ts[i] <= '0;
    end else begin
      ts_cnt     <= ts_cnt + 32'd1;
      pipe_ts[0] <= ts_cnt;
      for (int i = 1; i < RES_LAT; i++) pipe_ts[i] <= pipe_ts[i-1];
    end
  end
`endif

  // Push/pop decisions. A full FIFO still accepts a push when a pop frees a slot
  // on the same edge.
  assign push     = pipe_v[RES_LAT-1];
  assign push_rec = {pipe_cmd[RES_LAT-1], bus.c};
  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == FULL_LVL);
  assign pop      = !is_empty && bus.txn_ready;
  assign wr_en    = push && (!is_full || pop);
  assign drop     = push && is_full && !pop;

  // Record storage. There is no reset because outputs are masked by level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_rec;
`ifdef ALU_CAP_TIMESTAMP_EN
      mem_ts[wr_ptr] <= pipe_ts[RES_LAT-1];
`endif
    end
  end

  // Pointers wrap modulo DEPTH; level is the explicit occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Drop accounting: sticky flag plus a counter that saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
    end
  end

  // The head is presented only while it holds a record; otherwise it reads as zero
  assign bus.txn_valid = !is_empty;
  assign bus.txn_rec   = is_empty ? '0 : mem[rd_ptr];
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
`ifdef ALU_CAP_TIMESTAMP_EN
  assign bus.txn_ts    = is_empty ? '0 : mem_ts[rd_ptr];
`endif
endmodule

// File: tb/tb_alu_txn_capture.sv
// Directed self-checking bench for alu_txn_capture (DATA_W=8, RES_LAT=1, DEPTH=16).
// The stimulus result c is always A+B of the command sampled on the previous edge.
// When ALU_CAP_TIMESTAMP_EN is defined, the timestamp scenario also runs.
module tb_alu_txn_capture;
  localparam int DATA_W = 8;
  localparam int A_OP_W = 3;
  localparam int B_OP_W = 2;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int REC_W  = 2*DATA_W + A_OP_W + B_OP_W + 2 + DATA_W;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [DATA_W-1:0] prev_res;
  logic [REC_W-1:0]  exp_q[$];
  logic [REC_W-1:0]  exp_rec;

  alu_txn_if #(.DATA_W(DATA_W), .A_OP_W(A_OP_W), .B_OP_W(B_OP_W),
               .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alu_txn_capture #(.DATA_W(DATA_W), .A_OP_W(A_OP_W), .B_OP_W(B_OP_W), .RES_LAT(1),
                    .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [REC_W-1:0] make_rec(input logic ae, input logic be,
      input logic [2:0] aop, input logic [1:0] bop,
      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {ae, be, aop, bop, a, b, c};
  endfunction

  // Drive one cycle: a new command, plus c for the command sampled on the previous edge
  task automatic drive_cycle(input logic en, input logic ae, input logic be,
      input logic [2:0] aop, input logic [1:0] bop,
      input logic [7:0] a, input logic [7:0] b, input logic rdy);
    logic [7:0] sum;
    sum = a + b;
    bus.c         = prev_res;
    bus.alu_en    = en;
    bus.a_en      = ae;
    bus.b_en      = be;
    bus.a_op      = aop;
    bus.b_op      = bop;
    bus.A         = a;
    bus.B         = b;
    bus.txn_ready = rdy;
    if (en) exp_q.push_back(make_rec(ae, be, aop, bop, a, b, sum));
    prev_res = sum;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic rdy);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, rdy);
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.alu_en    = 1'b0;
    bus.a_en      = 1'b0;
    bus.b_en      = 1'b0;
    bus.a_op      = '0;
    bus.b_op      = '0;
    bus.A         = '0;
    bus.B         = '0;
    bus.c         = '0;
    bus.txn_ready = 1'b0;
    prev_res      = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Pop n records with ready held high and compare each head against the queue
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      exp_rec = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (bus.txn_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_valid[%0d]: got %b expected 1", i, bus.txn_valid);
      end
      n_checks++;
      if (bus.txn_rec !== exp_rec) begin
        n_fail++;
        $display("FAIL drain_rec[%0d]: got %h expected %h", i, bus.txn_rec, exp_rec);
      end
      idle_cycle(1'b1);
    end
    bus.txn_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.txn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.txn_valid); end
    n_checks++;
    if (bus.txn_rec !== '0) begin n_fail++; $display("FAIL rst_rec: got %h expected 0", bus.txn_rec); end
    n_checks++;
    if (bus.level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", bus.level); end
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", bus.overflow); end
    n_checks++;
    if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop_cnt: got %0d expected 0", bus.drop_cnt); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h05, 8'h03, 1'b0);
    n_checks++;
    if (bus.txn_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", bus.txn_valid); end
    idle_cycle(1'b0);
    n_checks++;
    if (bus.txn_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.txn_valid); end
    n_checks++;
    if (bus.txn_rec !== {1'b1, 1'b0, 3'd0, 2'd0, 8'h05, 8'h03, 8'h08}) begin
      n_fail++; $display("FAIL single_rec: got %h expected %h", bus.txn_rec, {1'b1, 1'b0, 3'd0, 2'd0, 8'h05, 8'h03, 8'h08});
    end
    n_checks++;
    if (bus.level !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", bus.level); end
    idle_cycle(1'b0);
    n_checks++;
    if (bus.txn_rec !== {1'b1, 1'b0, 3'd0, 2'd0, 8'h05, 8'h03, 8'h08}) begin
      n_fail++; $display("FAIL single_hold: got %h expected held record", bus.txn_rec);
    end
    drain(1);
    n_checks++;
    if (bus.txn_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", bus.txn_valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b1, i[0], i[1], i[2:0], i[1:0], 8'(i*7 + 1), 8'(i*3 + 2), 1'b0);
    idle_cycle(1'b0);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    n_checks++;
    if (bus.level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d expected 16", bus.level); end
    n_checks++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    n_checks++;
    if (bus.drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 4", bus.drop_cnt); end
    drain(16);
    n_checks++;
    if (bus.level !== 5'd0) begin n_fail++; $display("FAIL ovf_level_after: got %0d expected 0", bus.level); end
    n_checks++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
  endtask

  task automatic test_full_stream();
    apply_reset();
    for (int i = 0; i < 17; i++)
      drive_cycle(1'b1, i[1], i[0], i[2:0], i[1:0], 8'(i*11 + 4), 8'(i*5 + 9), 1'b0);
    n_checks++;
    if (bus.level !== 5'd16) begin n_fail++; $display("FAIL full_level_start: got %0d expected 16", bus.level); end
    for (int i = 0; i < 8; i++) begin
      exp_rec = exp_q.pop_front();
      n_checks++;
      if (bus.level !== 5'd16) begin n_fail++; $display("FAIL full_level[%0d]: got %0d expected 16", i, bus.level); end
      n_checks++;
      if (bus.txn_rec !== exp_rec) begin n_fail++; $display("FAIL full_rec[%0d]: got %h expected %h", i, bus.txn_rec, exp_rec); end
      n_checks++;
      if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL full_drop_cnt[%0d]: got %0d expected 0", i, bus.drop_cnt); end
      drive_cycle(1'b1, 1'b1, 1'b1, 3'(i + 2), 2'(i), 8'(8'hC0 + i), 8'(i*9), 1'b1);
    end
    drain(exp_q.size());
    n_checks++;
    if (bus.level !== 5'd0) begin n_fail++; $display("FAIL full_level_end: got %0d expected 0", bus.level); end
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_bubbles();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, i[2:0], i[1:0], 8'(i*37), 8'(~i), i[0]);
      n_checks++;
      if (bus.txn_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid[%0d]: got %b expected 0", i, bus.txn_valid); end
    end
    n_checks++;
    if (bus.level !== 5'd0) begin n_fail++; $display("FAIL bubble_level: got %0d expected 0", bus.level); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, 1'b0, 1'b1, i[2:0], i[1:0], 8'(i + 16), 8'(i + 32), 1'b0);
    n_checks++;
    if (bus.level !== 5'd7) begin n_fail++; $display("FAIL mid_level_before: got %0d expected 7", bus.level); end
    #2;
    rst = 1'b1;
    bus.alu_en = 1'b0;
    #1;
    n_checks++;
    if (bus.txn_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.txn_valid); end
    n_checks++;
    if (bus.level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", bus.level); end
    n_checks++;
    if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop_cnt: got %0d expected 0", bus.drop_cnt); end
    exp_q.delete();
    prev_res = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b1, 3'd5, 2'd2, 8'hA0, 8'h0F, 1'b0);
    idle_cycle(1'b0);
    n_checks++;
    if (bus.level !== 5'd1) begin n_fail++; $display("FAIL mid_post_level: got %0d expected 1", bus.level); end
    n_checks++;
    if (bus.txn_rec !== {1'b0, 1'b1, 3'd5, 2'd2, 8'hA0, 8'h0F, 8'hAF}) begin
      n_fail++; $display("FAIL mid_post_rec: got %h expected %h", bus.txn_rec, {1'b0, 1'b1, 3'd5, 2'd2, 8'hA0, 8'h0F, 8'hAF});
    end
    drain(1);
  endtask

`ifdef ALU_CAP_TIMESTAMP_EN
  task automatic test_timestamp();
    apply_reset();
    repeat (3) idle_cycle(1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 3'd1, 2'd0, 8'h11, 8'h22, 1'b0);
    repeat (5) idle_cycle(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, 3'd2, 2'd3, 8'h33, 8'h44, 1'b0);
    idle_cycle(1'b0);
    n_checks++;
    if (bus.txn_ts !== 32'd3) begin n_fail++; $display("FAIL ts_first: got %0d expected 3", bus.txn_ts); end
    idle_cycle(1'b1);
    bus.txn_ready = 1'b0;
    n_checks++;
    if (bus.txn_ts !== 32'd9) begin n_fail++; $display("FAIL ts_second: got %0d expected 9", bus.txn_ts); end
    void'(exp_q.pop_front());
    drain(1);
  endtask
`endif

  // test sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev_res = '0;
    test_reset();
    test_single();
    test_overflow();
    test_full_stream();
    test_bubbles();
    test_reset_mid_burst();
`ifdef ALU_CAP_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
